// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Resolves mem_busy freezes, taken-branch flushes and load-use stalls with
// same-cycle control outputs. It also keeps saturating event counters for debug.
module pipeline_hazard_ctrl #(
  parameter int PC_W         = 8,
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  IF_ID_Rs,
  input  logic [RA_W-1:0]  IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [RA_W-1:0]  ID_EX_Rd,
  input  logic             BranchTaken_EX,
  input  logic [PC_W-1:0]  BranchTarget_EX,
  input  logic             mem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Hold,
  output logic             BranchTaken,
  output logic [PC_W-1:0]  BranchTarget,
  output logic             ctrl_state,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0]       FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_nxt;
  logic [2:0] flush_left, flush_left_nxt;
  logic       load_use;
  logic       ls_inc, fl_inc, ms_inc;

  // A load in EX feeding a source used by ID. r0 is hardwired, so it never hazards.
  assign load_use = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                    ((ID_EX_Rd == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rd == IF_ID_Rt)));

  assign ctrl_state = state;

  // State register; reset aborts any flush in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  // Next state: a freeze holds everything, and a taken branch opens the flush window
  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    if (!mem_busy) begin
      if (state == RUN) begin
        if (BranchTaken_EX && (FLUSH_CYCLES > 1)) begin
          state_nxt      = FLUSH;
          flush_left_nxt = FL_INIT;
        end
      end else begin
        flush_left_nxt = flush_left - 3'd1;
        if (flush_left == 3'd1) state_nxt = RUN;
      end
    end
  end

  // Control outputs. Priority: reset, mem_busy, flush/branch, load-use
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Hold  = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    if (!rst) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (mem_busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      EX_MEM_Hold = 1'b1;
    end else if (state == FLUSH) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (BranchTaken_EX) begin
      BranchTaken  = 1'b1;
      BranchTarget = BranchTarget_EX;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  assign ls_inc = rst && !mem_busy && (state == RUN) && !BranchTaken_EX && load_use;
  assign fl_inc = rst && IF_ID_Flush;
  assign ms_inc = rst && mem_busy;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mem_stall_cnt  <= '0;
    end else begin
      if (ls_inc && (load_stall_cnt != CNT_MAX)) load_stall_cnt <= load_stall_cnt + CNT_ONE;
      if (fl_inc && (flush_cnt != CNT_MAX))      flush_cnt      <= flush_cnt + CNT_ONE;
      if (ms_inc && (mem_stall_cnt != CNT_MAX))  mem_stall_cnt  <= mem_stall_cnt + CNT_ONE;
    end
  end

endmodule
